// File: rtl/lpc_cycle_fifo.sv
// lpc_cycle_fifo: captures one encoded LPC cycle word per rising edge of the
// peripheral's ready strobe and queues it in a first-word-fall-through FIFO.
// Words with a null cycle type may be filtered out at capture time. Words lost
// to a full FIFO set a sticky overflow flag and bump a saturating drop counter.
module lpc_cycle_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DROP_NONE = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [31:0]                tdata_i,
  input  logic                       ready_i,
  input  logic                       clear_i,
  output logic [31:0]                m_tdata_o,
  output logic                       m_tvalid_o,
  input  logic                       m_tready_i,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic [15:0]                drop_cnt_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          ready_q;
  logic          overflow;
  logic [15:0]   drop_cnt;

  logic capture;
  logic null_type;
  logic accept;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Capture/push/pop/drop decode for the current cycle.
  always_comb begin
    capture   = ready_i & ~ready_q;
    null_type = (DROP_NONE != 0) && (tdata_i[1:0] == 2'b00);
    accept    = capture & ~null_type;
    full      = (level == FULL_LEVEL);
    pop       = (level != '0) & m_tready_i;
    // When full, a same-cycle pop frees the slot the new word goes into.
    push      = accept & (~full | pop);
    drop      = accept & full & ~pop;
  end

  // Strobe history, pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ready_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level   <= '0;
    end else begin
      ready_q <= ready_i;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      level <= level + LW'(1);
      else if (pop && !push) level <= level - LW'(1);
    end
  end

  // Storage array; contents are intentionally left out of reset.
  always_ff @(posedge clk_i) begin
    if (push && !rst_i) mem[wr_ptr] <= tdata_i;
  end

  // Sticky overflow flag and saturating drop counter; clear beats a drop.
  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  // Output assignments; head word falls through from storage.
  always_comb begin
    m_tdata_o  = mem[rd_ptr];
    m_tvalid_o = (level != '0);
    level_o    = level;
    overflow_o = overflow;
    drop_cnt_o = drop_cnt;
  end

endmodule

// File: tb/tb_lpc_cycle_fifo.sv
// Directed self-checking bench for lpc_cycle_fifo (DEPTH=16, DROP_NONE=1).
module tb_lpc_cycle_fifo;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] tdata;
  logic        ready;
  logic        clear;
  logic [31:0] m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic [4:0]  level;
  logic        overflow;
  logic [15:0] drop_cnt;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  lpc_cycle_fifo #(.DEPTH(16), .DROP_NONE(1)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .tdata_i    (tdata),
    .ready_i    (ready),
    .clear_i    (clear),
    .m_tdata_o  (m_tdata),
    .m_tvalid_o (m_tvalid),
    .m_tready_i (m_tready),
    .level_o    (level),
    .overflow_o (overflow),
    .drop_cnt_o (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Test word: address and data fields derived from i, cycle type = write.
  function automatic logic [31:0] word(input int unsigned i);
    logic [15:0] a;
    logic [7:0]  d;
    a = 16'(i + 16'h1000);
    d = 8'(i);
    return {4'h0, a, d, 2'b00, 2'b01};
  endfunction

  task automatic send(input logic [31:0] w);
    tdata = w;
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
  endtask

  task automatic drain_check(input string tag, input int unsigned first, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      check({tag, "_valid"}, 32'(m_tvalid), 32'd1);
      check({tag, "_data"}, m_tdata, word(first + i));
      m_tready = 1'b1;
      tick();
      m_tready = 1'b0;
    end
    check({tag, "_empty"}, 32'(level), 32'd0);
  endtask

  initial begin
    logic [31:0] q[$];
    logic        prev_ready;
    logic        cap;
    logic        pp;
    int unsigned sent;
    int unsigned got;
    int unsigned model_drops;

    rst = 1'b1; tdata = '0; ready = 1'b0; clear = 1'b0; m_tready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check("rst_level", 32'(level), 32'd0);
    check("rst_valid", 32'(m_tvalid), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);

    // Single word, strobe held for two cycles.
    tdata = 32'h0012_3451; ready = 1'b1;
    check("single_pre_valid", 32'(m_tvalid), 32'd0);
    tick();
    check("single_valid", 32'(m_tvalid), 32'd1);
    check("single_level1", 32'(level), 32'd1);
    tick();
    ready = 1'b0;
    check("single_level_hold", 32'(level), 32'd1);
    check("single_data", m_tdata, 32'h0012_3451);
    tick();
    check("single_level_after", 32'(level), 32'd1);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    check("single_popped", 32'(level), 32'd0);
    check("single_popped_valid", 32'(m_tvalid), 32'd0);

    // Null cycle type is filtered silently.
    send(32'h0000_0000);
    send(32'hABCD_0000);
    check("filter_level", 32'(level), 32'd0);
    check("filter_drop", 32'(drop_cnt), 32'd0);
    check("filter_ovf", 32'(overflow), 32'd0);

    // Pop while empty has no effect.
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    check("empty_pop_level", 32'(level), 32'd0);

    // Fill with 17 captures: 16 stored, one lost.
    for (int unsigned i = 1; i <= 17; i++) send(word(i));
    check("fill_level", 32'(level), 32'd16);
    check("fill_ovf", 32'(overflow), 32'd1);
    check("fill_drop", 32'(drop_cnt), 32'd1);
    tick(); tick();
    check("fill_head_stable", m_tdata, word(1));

    // Clear and a drop in the same cycle: clear wins.
    tdata = word(99); ready = 1'b1; clear = 1'b1;
    tick();
    ready = 1'b0; clear = 1'b0;
    tick();
    check("clear_ovf", 32'(overflow), 32'd0);
    check("clear_drop", 32'(drop_cnt), 32'd0);
    check("clear_level", 32'(level), 32'd16);
    drain_check("fill_drain", 1, 16);

    // Full FIFO with capture and pop in the same cycle.
    for (int unsigned i = 101; i <= 116; i++) send(word(i));
    check("fullpop_pre_level", 32'(level), 32'd16);
    tdata = word(117); ready = 1'b1; m_tready = 1'b1;
    tick();
    ready = 1'b0; m_tready = 1'b0;
    check("fullpop_level", 32'(level), 32'd16);
    check("fullpop_ovf", 32'(overflow), 32'd0);
    check("fullpop_drop", 32'(drop_cnt), 32'd0);
    tick();
    drain_check("fullpop_drain", 102, 16);

    // Wrap: 40 captures against random consumer back-pressure.
    q.delete();
    prev_ready = 1'b0;
    sent = 0; got = 0; model_drops = 0;
    for (int unsigned c = 0; c < 400 && (sent < 40 || q.size() != 0); c++) begin
      ready    = (c % 2 == 0) && (sent < 40);
      tdata    = word(300 + sent);
      m_tready = 1'($urandom_range(0, 1));
      cap = ready && !prev_ready;
      pp  = m_tready && (q.size() != 0);
      if (pp) begin
        check("wrap_data", m_tdata, q.pop_front());
        got++;
      end
      if (cap) begin
        if (q.size() < 16 || pp) q.push_back(word(300 + sent));
        else model_drops++;
        sent++;
      end
      prev_ready = ready;
      tick();
      check("wrap_level", 32'(level), 32'(q.size()));
      check("wrap_level_max", 32'(level <= 5'd16), 32'd1);
    end
    ready = 1'b0; m_tready = 1'b0;
    check("wrap_all_out", got + model_drops, 32'd40);
    check("wrap_drop", 32'(drop_cnt), model_drops);
    tick();

    // Reset mid-stream, with the strobe already high as reset releases.
    clear = 1'b1; tick(); clear = 1'b0;
    for (int unsigned i = 200; i < 205; i++) send(word(i));
    check("midrst_pre_level", 32'(level), 32'd5);
    rst = 1'b1; tdata = word(210); ready = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_level", 32'(level), 32'd0);
    check("midrst_valid", 32'(m_tvalid), 32'd0);
    check("midrst_ovf", 32'(overflow), 32'd0);
    tick();
    ready = 1'b0;
    check("midrst_cap_level", 32'(level), 32'd1);
    check("midrst_cap_data", m_tdata, word(210));
    tick();
    drain_check("midrst_drain", 210, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lpc_cycle_fifo.md
LPC_CYCLE_FIFO -- requirements
Module: lpc_cycle_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in 32-bit words; power of two, 4..256.
REQ-002 Parameter DROP_NONE, default 1; 1 = discard captured words whose cycle-type field [1:0] is 2'b00.
REQ-003 clk_i  input  1  LPC clock; single clock domain for the whole block.
REQ-004 rst_i  input  1  reset; synchronous, active-high.
REQ-005 tdata_i  input  32  encoded LPC cycle word from the peripheral: [27:12] address, [11:4] data, [1:0] type (01 write, 11 read).
REQ-006 ready_i  input  1  new-word strobe from the peripheral; may stay high for 1 or more cycles per word.
REQ-007 clear_i  input  1  clears overflow_o and drop_cnt_o; does not touch FIFO contents.
REQ-008 m_tdata_o  output  32  head-of-FIFO word.
REQ-009 m_tvalid_o  output  1  head word valid.
REQ-010 m_tready_i  input  1  consumer accepts head word.
REQ-011 level_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
REQ-012 overflow_o  output  1  sticky; a word was lost because the FIFO was full.
REQ-013 drop_cnt_o  output  16  count of words lost to full condition; saturates at 16'hFFFF.

Function
REQ-014 Capture event = ready_i high in this cycle and low in the previous cycle (rising-edge detect on a registered copy); exactly one capture per high pulse regardless of pulse length.
REQ-015 On a capture event, tdata_i is sampled in the same cycle as the edge.
REQ-016 DROP_NONE=1 and tdata_i[1:0]==2'b00 at capture: word discarded silently; no push, no drop_cnt_o change, no overflow_o change.
REQ-017 Push = accepted capture event with level_o < DEPTH, or level_o == DEPTH with a pop in the same cycle.
REQ-018 Capture with level_o == DEPTH and no pop in the same cycle: word lost; overflow_o <= 1; drop_cnt_o increments by 1 unless it is already 16'hFFFF.
REQ-019 Pop = m_tvalid_o && m_tready_i; head advances on the same clock edge.
REQ-020 First-word-fall-through: m_tvalid_o = (level_o != 0); m_tdata_o presents the oldest word combinationally from the storage array.
REQ-021 Latency: a word pushed at edge N is visible on m_tdata_o/m_tvalid_o after edge N (one cycle), including when the FIFO was empty.
REQ-022 Simultaneous push and pop: level_o unchanged; both pointers advance.
REQ-023 Pop attempted while empty (m_tready_i high, m_tvalid_o low): no effect.
REQ-024 Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH; full/empty are derived from level_o, not from pointer equality.
REQ-025 Word order is preserved exactly; no word is duplicated.
REQ-026 clear_i and a drop in the same cycle: clear wins; overflow_o = 0 and drop_cnt_o = 0 afterwards.
REQ-027 m_tdata_o is stable while m_tvalid_o is high and m_tready_i is low.

Reset
REQ-028 While rst_i is high at an edge: pointers = 0, level_o = 0, m_tvalid_o = 0, overflow_o = 0, drop_cnt_o = 0, registered ready_i copy = 0; storage contents are not reset.
REQ-029 Reset asserted mid-operation discards all queued words; a ready_i pulse that is already high when reset deasserts counts as a rising edge on the first cycle after reset.
REQ-030 m_tdata_o value is don't-care while m_tvalid_o is low.

Verification
REQ-031 Single word: ready_i high for 2 cycles with tdata_i=32'h0012_3451 -> exactly one push; m_tvalid_o rises one cycle later; m_tdata_o=32'h0012_3451; level_o=1.
REQ-032 Filter: DROP_NONE=1, capture tdata_i=32'h0000_0000 -> level_o stays 0, drop_cnt_o stays 0.
REQ-033 Fill: 17 captures with m_tready_i=0, DEPTH=16 -> level_o=16; overflow_o=1; drop_cnt_o=1; drained data equals words 1..16 in order.
REQ-034 Full with concurrent pop: level_o=16, capture and pop in the same cycle -> level_o stays 16; no drop; overflow_o stays 0.
REQ-035 Wrap: 40 captures interleaved with pops at random m_tready_i -> output sequence identical to input sequence; level_o never exceeds 16.
REQ-036 Reset mid-stream: level_o=5, rst_i high for 1 cycle -> level_o=0, m_tvalid_o=0, overflow_o=0 on the following cycle; the next capture is the first word output.
